// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM port arbiter slice.
// - state_t        : controller FSM states
// - ADDR_WIDTH_DEF : default RAM address width
// - DATA_WIDTH_DEF : default RAM data width
package ram_ctrl_pkg;

  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// - clk, rst_n : clock, asynchronous active-low reset
// - req        : request vector from the two clients
// - advance    : a grant is being issued this cycle; remember who won
// - winner     : one-hot winner (zero when no request)
// A lone request always wins; under contention the requester that did not
// win last time is chosen. last_winner resets to 1 so requester 0 takes the
// first contended grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] winner
);

  logic last_winner;

  always_comb begin
    winner = 2'b00;
    unique case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last_winner ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner <= 1'b1;
    end else if (advance) begin
      last_winner <= winner[1];
    end
  end

endmodule

// File: rtl/single_port_sync_ram.sv
// Single-port synchronous RAM with chip select, write enable and output enable
// on a shared bidirectional data bus.
// - clk, rst_n      : clock, asynchronous active-low reset (output register only)
// - chip_select     : access enable
// - write_enable    : 1 = write the bus value at the next edge
// - output_enable   : with chip_select and !write_enable, registers mem[address]
//                     at the edge and drives it onto the bus
// - address, data   : address and shared data bus
// Read data appears one edge after the read command is first seen.
module single_port_sync_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  chip_select,
  input  logic                  write_enable,
  input  logic                  output_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] dout;

  // NOTE: the array itself is never reset; RAM macros have no reset and a
  // reset loop over every word would not map onto block memory.
  always_ff @(posedge clk) begin
    if (chip_select && write_enable) begin
      mem[address] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (chip_select && output_enable && !write_enable) begin
      dout <= mem[address];
    end
  end

  assign data = (chip_select && output_enable && !write_enable) ? dout : 'z;

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin controller for single_port_sync_ram.
// - clk, rst_n            : clock, asynchronous active-low reset
// - req, req_we           : per-requester request (held until gnt) and op (1=write)
// - req_addr0/1           : per-requester address
// - req_wdata0/1          : per-requester write data
// - gnt                   : one-cycle pulse, request accepted and inputs latched
// - ack                   : one-cycle pulse, op complete (read: rdata valid)
// - rdata                 : last read data, held until the next read completes
// - busy                  : high whenever the FSM is not IDLE
// - ram_cs/we/oe/addr     : registered RAM command outputs
// - ram_data              : shared bus, driven only for writes
// Sequence: IDLE -(gnt)-> ACCESS -(write ack)-> IDLE
//                             \-(read)-> CAPTURE -(ack, rdata)-> IDLE
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]            gnt,
  output logic [1:0]            ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  state_t                state, state_d;
  logic [1:0]            winner;
  logic                  advance;
  logic [1:0]            gnt_d, ack_d;
  logic                  cs_d, we_d, oe_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  op_we_q, op_we_d;
  logic                  op_idx_q, op_idx_d;

  // New requests are only looked at on the edge that leaves IDLE.
  assign advance = (state == IDLE) && (req != 2'b00);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .winner  (winner)
  );

  // NOTE: every variable gets a default at the top of the block, so paths
  // that do not assign it cannot infer a latch.
  always_comb begin
    state_d  = state;
    gnt_d    = 2'b00;
    ack_d    = 2'b00;
    cs_d     = ram_cs;
    we_d     = ram_we;
    oe_d     = ram_oe;
    addr_d   = ram_addr;
    rdata_d  = rdata;
    wdata_d  = wdata_q;
    op_we_d  = op_we_q;
    op_idx_d = op_idx_q;

    unique case (state)
      IDLE: begin
        if (advance) begin
          op_idx_d = winner[1];
          op_we_d  = req_we[winner[1]];
          addr_d   = winner[1] ? req_addr1 : req_addr0;
          wdata_d  = winner[1] ? req_wdata1 : req_wdata0;
          gnt_d    = winner;
          cs_d     = 1'b1;
          we_d     = req_we[winner[1]];
          oe_d     = !req_we[winner[1]];
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (op_we_q) begin
          ack_d[op_idx_q] = 1'b1;
          cs_d            = 1'b0;
          we_d            = 1'b0;
          state_d         = IDLE;
        end else begin
          // RAM registers the word on this edge; it is on the bus next cycle.
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rdata_d         = ram_data;
        ack_d[op_idx_q] = 1'b1;
        cs_d            = 1'b0;
        oe_d            = 1'b0;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        oe_d    = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      ack      <= 2'b00;
      rdata    <= '0;
      busy     <= 1'b0;
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
      ram_oe   <= 1'b0;
      ram_addr <= '0;
      wdata_q  <= '0;
      op_we_q  <= 1'b0;
      op_idx_q <= 1'b0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      ack      <= ack_d;
      rdata    <= rdata_d;
      busy     <= (state_d != IDLE);
      ram_cs   <= cs_d;
      ram_we   <= we_d;
      ram_oe   <= oe_d;
      ram_addr <= addr_d;
      wdata_q  <= wdata_d;
      op_we_q  <= op_we_d;
      op_idx_q <= op_idx_d;
    end
  end

  // Enable decodes straight from the registered controls, so reset releases
  // the bus at once and it is never driven while the RAM may be driving.
  assign ram_data = (ram_cs && ram_we && !ram_oe) ? wdata_q : 'z;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a RAM model on the
// ram_* ports. Inputs are driven and outputs sampled on the falling edge.
module tb_ram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [1:0]    req_we = 2'b00;
  logic [AW-1:0] req_addr0 = '0;
  logic [AW-1:0] req_addr1 = '0;
  logic [DW-1:0] req_wdata0 = '0;
  logic [DW-1:0] req_wdata1 = '0;
  logic [1:0]    gnt, ack;
  logic [DW-1:0] rdata;
  logic          busy, ram_cs, ram_we, ram_oe;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  int tests = 0;
  int failed = 0;
  int bus_bad = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  single_port_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_ram (
    .clk(clk), .rst_n(rst_n), .chip_select(ram_cs), .write_enable(ram_we),
    .output_enable(ram_oe), .address(ram_addr), .data(ram_data)
  );

  // Bus must be either fully released or fully driven with known bits.
  always @(negedge clk) begin
    if (rst_n && (ram_data !== 8'hzz) && $isunknown(ram_data)) bus_bad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input int idx, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, output logic [DW-1:0] rd);
    int n;
    req_we[idx] = we;
    if (idx == 0) begin req_addr0 = addr; req_wdata0 = wd; end
    else          begin req_addr1 = addr; req_wdata1 = wd; end
    req[idx] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt[idx] && n < 20);
    check("op_gnt", {31'd0, gnt[idx]}, 32'd1);
    req[idx] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack[idx] && n < 20);
    check("op_ack", {31'd0, ack[idx]}, 32'd1);
    rd = rdata;
  endtask

  logic [DW-1:0] rd;
  logic [DW-1:0] sweep_data [17];
  logic [AW-1:0] sweep_addr [17];
  int ng, cyc, both_err;

  initial begin
    // Reset state
    #12;
    check("rst_out", {gnt, ack, rdata, busy, ram_cs, ram_we, ram_oe}, 32'd0);
    check("rst_addr", ram_addr, 32'd0);
    check("rst_busz", (ram_data === 8'hzz), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out", {gnt, ack, rdata, busy, ram_cs, ram_we, ram_oe}, 32'd0);
    check("post_rst_busz", (ram_data === 8'hzz), 32'd1);

    // Write by requester 0: 0xA5 -> 0x005
    req_we = 2'b01; req_addr0 = 10'h005; req_wdata0 = 8'hA5; req = 2'b01;
    @(negedge clk);                               // after E0
    check("wr_gnt", gnt, 32'b01);
    check("wr_ctl", {ram_cs, ram_we, ram_oe, busy}, 32'b1101);
    check("wr_addr", ram_addr, 32'h005);
    check("wr_bus", ram_data, 32'hA5);
    req = 2'b00; req_wdata0 = 8'h00;              // changes after gnt are ignored
    @(negedge clk);                               // after E1
    check("wr_ack", {gnt, ack}, 32'b0001);
    check("wr_ctl_off", {ram_cs, ram_we, ram_oe, busy}, 32'b0000);
    check("wr_busz", (ram_data === 8'hzz), 32'd1);
    check("wr_mem", u_ram.mem[5], 32'hA5);

    // Read by requester 1 from 0x005
    req_we = 2'b00; req_addr1 = 10'h005; req = 2'b10;
    @(negedge clk);                               // after E0
    check("rd_gnt", gnt, 32'b10);
    check("rd_ctl0", {ram_cs, ram_we, ram_oe, busy}, 32'b1011);
    req = 2'b00;
    @(negedge clk);                               // after E1
    check("rd_ctl1", {ram_cs, ram_we, ram_oe, ack}, 32'b10100);
    @(negedge clk);                               // after E2
    check("rd_ack", ack, 32'b10);
    check("rd_data", rdata, 32'hA5);
    check("rd_ctl_off", {ram_cs, ram_oe, busy}, 32'b000);
    @(negedge clk);
    check("rd_hold", {ack, rdata}, {22'd0, 2'b00, 8'hA5});

    // Contention: both requesters writing continuously for 8 grants
    req_we = 2'b11; req_addr0 = 10'h100; req_addr1 = 10'h200;
    req_wdata0 = 8'h11; req_wdata1 = 8'h22; req = 2'b11;
    ng = 0; cyc = 0; both_err = 0;
    while (ng < 8 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (gnt == 2'b11) both_err++;
      if (gnt != 2'b00) begin
        check($sformatf("rr_gnt%0d", ng), gnt, (ng % 2 == 0) ? 32'b01 : 32'b10);
        ng++;
        if (ng == 8) req = 2'b00;
      end
    end
    check("rr_count", ng, 32'd8);
    check("rr_both", both_err, 32'd0);
    cyc = 0;
    while (busy && cyc < 20) begin @(negedge clk); cyc++; end
    check("rr_idle", busy, 32'd0);
    check("rr_mem", {u_ram.mem[10'h100], u_ram.mem[10'h200]}, 32'h1122);

    // Reset during CAPTURE
    req_we = 2'b00; req_addr0 = 10'h005; req = 2'b01;
    @(negedge clk);                               // ACCESS
    req = 2'b00;
    @(negedge clk);                               // CAPTURE
    check("mr_in_capture", {ram_cs, ram_oe}, 32'b11);
    rst_n = 1'b0;
    #1;
    check("mr_ctl", {ram_cs, ram_we, ram_oe, busy, ack}, 32'd0);
    check("mr_busz", (ram_data === 8'hzz), 32'd1);
    @(negedge clk);
    check("mr_noack", ack, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_rdata_rst", rdata, 32'd0);
    do_op(0, 1'b0, 10'h005, 8'h00, rd);
    check("mr_reread", rd, 32'hA5);

    // Sweep: write via alternating requesters, read back via the other one
    for (int i = 0; i < 17; i++) begin
      sweep_addr[i] = (i < 16) ? AW'(i) : 10'h3FF;
      sweep_data[i] = DW'($urandom_range(0, 255));
      do_op(i % 2, 1'b1, sweep_addr[i], sweep_data[i], rd);
    end
    for (int i = 0; i < 17; i++) begin
      do_op((i + 1) % 2, 1'b0, sweep_addr[i], 8'h00, rd);
      check($sformatf("sweep_%03h", sweep_addr[i]), rd, {24'd0, sweep_data[i]});
    end
    check("sweep_top_addr", u_ram.mem[10'h3FF], {24'd0, sweep_data[16]});

    @(negedge clk);
    check("bus_never_x", bus_bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
